// File: rtl/ctrl_lgc.sv
// ctrl_lgc: control logic for an 8259-style programmable interrupt controller.
//
// Purpose:
//   - Decodes ICW1-4 and the OCW2/OCW3 commands.
//   - Holds the mode bits LTIM, SNGL, IC4, AEOI and BUF.
//   - Raises the CPU interrupt request.
//   - Runs the two-pulse INTA handshake that sets the ISR bit and enables
//     the vector drivers.
//   - Issues EOI pulses and selects which register the read path returns.
//
// Configuration:
//   CTRLLGC_AEOI_EN
//     Defined:   ICW4 D[1] sets automatic-EOI mode, and an EOI pulse follows
//                the second INTA pulse.
//     Undefined: ar is held at 0 and EOI comes only from OCW2.
//
// Ports:
//   clk, reset      rising-edge clock; synchronous active-high reset
//   D, a0           write data and address bit of the current bus access
//   wrflg, rdflag   one-cycle write and read strobes
//   inta            interrupt acknowledge level, synchronous to clk
//   S               SP/EN pin: 1 = master, 0 = slave
//   CLsig           cascade address matches this device
//   R               winning request vector from the resolver (bit 0 highest)
//   Mask            IMR contents
//   isr, irr        any ISR bit set / any IRR bit set
//   isprior         winning request outranks the highest in-service level
//   intr            registered interrupt request to the CPU
//                   (named intr because int is a reserved keyword)
//   ino             one-cycle pulse that sets ISR bit Y and clears its IRR bit
//   en              vector/data bus drive enable (combinational)
//   buff, LTIM, ar  ICW4 BUF, ICW1 LTIM and ICW4 AEOI mode bits
//   eoi             one-cycle EOI pulse to the ISR block
//   rwadr           one-hot read select: 001 IRR, 010 ISR, 100 IMR
//                   (combinational override during IMR reads)
//   Y               level of the acknowledged request, latched at the first INTA
module ctrl_lgc (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] D,
    input  logic       a0,
    input  logic       wrflg,
    input  logic       rdflag,
    input  logic       inta,
    input  logic       S,
    input  logic       CLsig,
    input  logic [7:0] R,
    input  logic [7:0] Mask,
    input  logic       isr,
    input  logic       irr,
    input  logic       isprior,
    output logic       intr,
    output logic       ino,
    output logic       en,
    output logic       buff,
    output logic       LTIM,
    output logic       eoi,
    output logic       ar,
    output logic [2:0] rwadr,
    output logic [2:0] Y
);

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 2;

    localparam logic [SW-1:0] SEL_IRR = 3'b001;
    localparam logic [SW-1:0] SEL_ISR = 3'b010;
    localparam logic [SW-1:0] SEL_IMR = 3'b100;

    localparam logic [CW-1:0] CNT_IDLE = 2'd0;
    localparam logic [CW-1:0] CNT_ONE  = 2'd1;
    localparam logic [CW-1:0] CNT_TWO  = 2'd2;

    typedef enum logic [2:0] {
        UNINIT = 3'd0,
        W_ICW2 = 3'd1,
        W_ICW3 = 3'd2,
        W_ICW4 = 3'd3,
        READY  = 3'd4
    } state_t;

    state_t        state, state_n;
    logic          sngl, sngl_n;
    logic          ic4, ic4_n;
    logic          ltim_n, buff_n, ar_n;
    logic [SW-1:0] sel_q, sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] y_n;
    logic          ino_n, eoi_n, int_n;
    logic          inta_d;

    logic          icw1, wr_hi, ocw2, ocw3;
    logic          ready, inta_rise, inta_fall, ack_rise, ack_fall;
    logic          pending, slave_ok, rd_en, inta_en;
    logic          unused_dbits;

    // Data bits this block never inspects.
    assign unused_dbits = ^{D[7:6], D[2]};

    // Binary index of the lowest set bit; 0 when nothing is set.
    function automatic logic [SW-1:0] lsb_enc(input logic [DW-1:0] v);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (v[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    // Command decode.
    assign icw1  = wrflg & ~a0 & D[4];
    assign wr_hi = wrflg & a0;
    assign ocw2  = wrflg & ~a0 & (D[4:3] == 2'b00);
    assign ocw3  = wrflg & ~a0 & (D[4:3] == 2'b01);
    assign ready = (state == READY);

    // INTA edges count only in READY, and an ICW1 in the same cycle discards them.
    assign inta_rise = inta & ~inta_d;
    assign inta_fall = ~inta & inta_d;
    assign ack_rise  = inta_rise & ready & ~icw1;
    assign ack_fall  = inta_fall & ready & ~icw1;

    // Unmasked request that the in-service state allows through.
    assign pending = irr & (|(R & ~Mask)) & (~isr | isprior);

    // Bus drive: during a read in unbuffered mode, or for the whole second
    // INTA pulse (including its rising-edge cycle) when this device supplies
    // the vector.
    assign slave_ok = S | sngl | CLsig;
    assign rd_en    = rdflag & ~buff;
    assign inta_en  = inta & ready & slave_ok &
                      ((cnt == CNT_TWO) | ((cnt == CNT_ONE) & inta_rise & ~icw1));
    assign en       = rd_en | inta_en;

    // IMR reads override the stored select for that cycle only.
    assign rwadr = (rdflag & a0) ? SEL_IMR : sel_q;

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        sngl_n  = sngl;
        ic4_n   = ic4;
        ltim_n  = LTIM;
        buff_n  = buff;
        ar_n    = ar;
        sel_n   = sel_q;
        cnt_n   = cnt;
        y_n     = Y;
        ino_n   = 1'b0;
        eoi_n   = 1'b0;
        int_n   = 1'b0;

        if (icw1) begin
            ltim_n  = D[3];
            sngl_n  = D[1];
            ic4_n   = D[0];
            ar_n    = 1'b0;
            buff_n  = 1'b0;
            sel_n   = SEL_IRR;
            cnt_n   = CNT_IDLE;
            state_n = W_ICW2;
        end else begin
            case (state)
                W_ICW2: begin
                    if (wr_hi) begin
                        if (!sngl)    state_n = W_ICW3;
                        else if (ic4) state_n = W_ICW4;
                        else          state_n = READY;
                    end
                end
                W_ICW3: begin
                    if (wr_hi) state_n = ic4 ? W_ICW4 : READY;
                end
                W_ICW4: begin
                    if (wr_hi) begin
                        buff_n  = D[3];
`ifdef CTRLLGC_AEOI_EN
                        ar_n    = D[1];
`else
                        ar_n    = 1'b0;
`endif
                        state_n = READY;
                    end
                end
                READY: begin
                    if (ocw2 && D[5]) eoi_n = 1'b1;
                    if (ocw3 && D[1]) sel_n = D[0] ? SEL_ISR : SEL_IRR;

                    // Two-pulse acknowledge: the first edge latches the
                    // level and sets the ISR; the second edge enables the
                    // vector; the trailing fall ends the sequence.
                    if (ack_rise && cnt == CNT_IDLE) begin
                        cnt_n = CNT_ONE;
                        ino_n = 1'b1;
                        y_n   = lsb_enc(R);
                    end else if (ack_rise && cnt == CNT_ONE) begin
                        cnt_n = CNT_TWO;
                    end else if (ack_fall && cnt == CNT_TWO) begin
                        cnt_n = CNT_IDLE;
                        if (ar) eoi_n = 1'b1;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end

        // Evaluated on next-cycle state so the request drops together with ino.
        int_n = (state_n == READY) & pending & (cnt_n == CNT_IDLE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= UNINIT;
        else       state <= state_n;
    end

    // Mode, sequence and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sngl   <= 1'b0;
            ic4    <= 1'b0;
            LTIM   <= 1'b0;
            buff   <= 1'b0;
            ar     <= 1'b0;
            sel_q  <= SEL_IRR;
            cnt    <= CNT_IDLE;
            Y      <= '0;
            ino    <= 1'b0;
            eoi    <= 1'b0;
            intr   <= 1'b0;
            inta_d <= 1'b0;
        end else begin
            sngl   <= sngl_n;
            ic4    <= ic4_n;
            LTIM   <= ltim_n;
            buff   <= buff_n;
            ar     <= ar_n;
            sel_q  <= sel_n;
            cnt    <= cnt_n;
            Y      <= y_n;
            ino    <= ino_n;
            eoi    <= eoi_n;
            intr   <= int_n;
            inta_d <= inta;
        end
    end

endmodule

// File: tb/tb_ctrl_lgc.sv
// tb_ctrl_lgc: directed bench for ctrl_lgc. Inputs change 1 ns after the
// rising edge, and outputs are sampled there too, so samples never sit on an
// active edge.
module tb_ctrl_lgc;

    logic       clk;
    logic       reset;
    logic [7:0] D;
    logic       a0;
    logic       wrflg;
    logic       rdflag;
    logic       inta;
    logic       S;
    logic       CLsig;
    logic [7:0] R;
    logic [7:0] Mask;
    logic       isr;
    logic       irr;
    logic       isprior;
    logic       intr;
    logic       ino;
    logic       en;
    logic       buff;
    logic       LTIM;
    logic       eoi;
    logic       ar;
    logic [2:0] rwadr;
    logic [2:0] Y;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef CTRLLGC_AEOI_EN
    localparam logic [7:0] AR_EXP = 8'd1;
`else
    localparam logic [7:0] AR_EXP = 8'd0;
`endif

    ctrl_lgc dut (
        .clk     (clk),
        .reset   (reset),
        .D       (D),
        .a0      (a0),
        .wrflg   (wrflg),
        .rdflag  (rdflag),
        .inta    (inta),
        .S       (S),
        .CLsig   (CLsig),
        .R       (R),
        .Mask    (Mask),
        .isr     (isr),
        .irr     (irr),
        .isprior (isprior),
        .intr    (intr),
        .ino     (ino),
        .en      (en),
        .buff    (buff),
        .LTIM    (LTIM),
        .eoi     (eoi),
        .ar      (ar),
        .rwadr   (rwadr),
        .Y       (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        a0    = a;
        D     = d;
        wrflg = 1'b1;
        tick();
        wrflg = 1'b0;
        a0    = 1'b0;
        D     = 8'h00;
    endtask

    initial begin
        reset = 1'b1; D = 8'h00; a0 = 1'b0; wrflg = 1'b0; rdflag = 1'b0;
        inta = 1'b0; S = 1'b1; CLsig = 1'b0; R = 8'h00; Mask = 8'h00;
        isr = 1'b0; irr = 1'b0; isprior = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // Reset values.
        check("rst_int",   8'(intr),  8'd0);
        check("rst_ino",   8'(ino),   8'd0);
        check("rst_en",    8'(en),    8'd0);
        check("rst_eoi",   8'(eoi),   8'd0);
        check("rst_ar",    8'(ar),    8'd0);
        check("rst_buff",  8'(buff),  8'd0);
        check("rst_ltim",  8'(LTIM),  8'd0);
        check("rst_rwadr", 8'(rwadr), 8'd1);
        check("rst_y",     8'(Y),     8'd0);

        // Master, single, ICW4: LTIM=1, BUF=1, AEOI=1.
        wr(1'b0, 8'h1B);
        wr(1'b1, 8'h20);
        wr(1'b1, 8'h0B);
        check("init_ltim", 8'(LTIM), 8'd1);
        check("init_buff", 8'(buff), 8'd1);
        check("init_ar",   8'(ar),   AR_EXP);

        // Request on level 2.
        R = 8'h04; Mask = 8'h00; irr = 1'b1; isr = 1'b0;
        tick();
        check("req_int", 8'(intr), 8'd1);

        // First INTA pulse.
        inta = 1'b1;
        tick();
        check("a1_ino", 8'(ino),  8'd1);
        check("a1_y",   8'(Y),    8'd2);
        check("a1_int", 8'(intr), 8'd0);
        isr = 1'b1; isprior = 1'b0;
        inta = 1'b0;
        tick();
        check("a1_ino_off", 8'(ino), 8'd0);
        check("a1_en_off",  8'(en),  8'd0);

        // Second INTA pulse.
        inta = 1'b1;
        #1;
        check("a2_en_edge", 8'(en),  8'd1);
        check("a2_eoi_pre", 8'(eoi), 8'd0);
        tick();
        check("a2_en_hold", 8'(en), 8'd1);
        inta = 1'b0;
        #1;
        check("a2_en_low", 8'(en), 8'd0);
        tick();
        check("aeoi_pulse", 8'(eoi),  AR_EXP);
        check("aeoi_int",   8'(intr), 8'd0);
        tick();
        check("aeoi_end", 8'(eoi), 8'd0);

        // Masking and priority gating.
        isr = 1'b0; Mask = 8'h04;
        tick();
        check("mask_int", 8'(intr), 8'd0);
        Mask = 8'h00; isr = 1'b1; isprior = 1'b0;
        tick();
        check("isr_block_int", 8'(intr), 8'd0);
        isprior = 1'b1;
        tick();
        check("isprior_int", 8'(intr), 8'd1);
        irr = 1'b0; isr = 1'b0; isprior = 1'b0;
        tick();
        check("irr_low_int", 8'(intr), 8'd0);

        // OCW3 read select, IMR read override, OCW2 EOI.
        wr(1'b0, 8'h0B);
        check("ocw3_rwadr", 8'(rwadr), 8'd2);
        rdflag = 1'b1; a0 = 1'b1;
        #1;
        check("imr_rwadr",   8'(rwadr), 8'd4);
        check("rd_en_buff1", 8'(en),    8'd0);
        tick();
        rdflag = 1'b0; a0 = 1'b0;
        #1;
        check("rwadr_back", 8'(rwadr), 8'd2);
        wr(1'b0, 8'h20);
        check("ocw2_eoi", 8'(eoi), 8'd1);
        tick();
        check("ocw2_eoi_end", 8'(eoi), 8'd0);

        // Cascade mode with ICW3 and ICW4: BUF=0, AEOI=0.
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h20);
        wr(1'b1, 8'h00);
        wr(1'b1, 8'h01);
        check("slv_buff",  8'(buff),  8'd0);
        check("slv_ltim",  8'(LTIM),  8'd0);
        check("slv_ar",    8'(ar),    8'd0);
        check("slv_rwadr", 8'(rwadr), 8'd1);
        rdflag = 1'b1;
        #1;
        check("rd_en_buff0", 8'(en), 8'd1);
        tick();
        rdflag = 1'b0;

        // Slave without cascade match: no vector drive.
        S = 1'b0; CLsig = 1'b0; R = 8'h30; Mask = 8'h00; irr = 1'b1; isr = 1'b0;
        tick();
        check("slv_int", 8'(intr), 8'd1);
        inta = 1'b1;
        tick();
        check("slv_y", 8'(Y), 8'd4);
        inta = 1'b0;
        tick();
        inta = 1'b1;
        #1;
        check("slv_en_edge", 8'(en), 8'd0);
        tick();
        check("slv_en_hold", 8'(en), 8'd0);
        inta = 1'b0;
        tick();
        check("slv_no_eoi", 8'(eoi),  8'd0);
        check("slv_reint",  8'(intr), 8'd1);

        // Slave with cascade match: vector drive enabled.
        CLsig = 1'b1;
        inta = 1'b1;
        tick();
        inta = 1'b0;
        tick();
        inta = 1'b1;
        #1;
        check("cls_en_edge", 8'(en), 8'd1);
        tick();
        check("cls_en_hold", 8'(en), 8'd1);
        inta = 1'b0;
        tick();

        // ICW1 between the INTA pulses aborts the sequence.
        inta = 1'b1;
        tick();
        inta = 1'b0;
        tick();
        wr(1'b0, 8'h11);
        check("abort_int", 8'(intr), 8'd0);
        inta = 1'b1;
        #1;
        check("abort_en_edge", 8'(en), 8'd0);
        tick();
        check("abort_en", 8'(en),  8'd0);
        check("abort_ino", 8'(ino), 8'd0);
        inta = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ctrl_lgc.md
Name: ctrl_lgc

Overview:
Control-logic block of the 8259-style programmable interrupt controller. It decodes ICW1-4 and OCW2/3 writes and holds mode bits (LTIM, AEOI, BUF). It generates the INT request and runs the two-pulse INTA sequence that strobes the ISR set and drives the vector bus enable. It also issues EOI commands and selects which register the read path returns. It sits between the bus interface and the IRR, ISR, IMR and priority-resolver blocks.

Parameters:
none

Ports:
clk  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
D  in  8  write data from bus interface
a0  in  1  address bit A0 of current access
wrflg  in  1  one-cycle write strobe
rdflag  in  1  one-cycle read strobe
inta  in  1  interrupt acknowledge, active-high level, synchronous to clk
S  in  1  SP/EN pin: 1 = master, 0 = slave
CLsig  in  1  cascade address matches this device (slave use)
R  in  8  resolver winning request vector; bit 0 is highest priority
Mask  in  8  current IMR contents
isr  in  1  any ISR bit set
irr  in  1  any IRR bit set
isprior  in  1  winning request outranks highest in-service level
int  out  1  interrupt request to CPU
ino  out  1  one-cycle pulse: set ISR bit Y, clear its IRR bit
en  out  1  vector/data bus drive enable
buff  out  1  ICW4 BUF bit
LTIM  out  1  ICW1 level-trigger bit
eoi  out  1  one-cycle EOI pulse to ISR block
ar  out  1  ICW4 AEOI bit
rwadr  out  3  read select, one-hot: 001 IRR, 010 ISR, 100 IMR
Y  out  3  binary level of lowest set bit of R, latched at first INTA

Behaviour:
- Reset (sync): init state UNINIT. Outputs int, ino, en, buff, LTIM, eoi, ar = 0; Y = 0; rwadr = 001; INTA counter = 0.
- Init FSM states: UNINIT, W_ICW2, W_ICW3, W_ICW4, READY.
- ICW1 = wrflg & !a0 & D[4], accepted in any state.
  - Latches LTIM = D[3], SNGL = D[1], IC4 = D[0].
  - Clears ar and buff, sets rwadr = 001, aborts any INTA sequence, goes to W_ICW2.
- W_ICW2: next wrflg with a0 = 1 is accepted; data is ignored by this block. Next state: W_ICW3 if !SNGL, else W_ICW4 if IC4, else READY.
- W_ICW3: wrflg with a0 = 1 is accepted. Next state: W_ICW4 if IC4, else READY.
- W_ICW4: wrflg with a0 = 1 latches ar = D[1], buff = D[3]; next state READY.
- In W_ICW2/3/4, writes with a0 = 0 other than ICW1 are ignored.
- READY, writes:
  - a0 = 1 (OCW1): ignored here, since the IMR is external.
  - a0 = 0, D[4:3] = 00 (OCW2): if D[5] = 1, eoi pulses high for exactly one cycle, starting the cycle after the write.
  - a0 = 0, D[4:3] = 01 (OCW3): if D[1] = 1, rwadr = D[0] ? 010 : 001; otherwise unchanged.
- Reads: rwadr is combinationally forced to 100 while rdflag & a0, otherwise shows the stored select. en = 1 for the cycle of rdflag when buff = 0.
- int, registered: 1 iff state == READY & irr & (R & ~Mask) != 0 & (!isr | isprior) & no INTA sequence active. Otherwise 0.
- INTA sequence, counted on rising edges of inta:
  - 1st edge: ino pulses one cycle. Y latches the encode of lowest set bit of R (0 if R == 0). int drops to 0.
  - 2nd edge: en = 1 while inta stays high, if S = 1 or SNGL = 1 or CLsig = 1; otherwise en stays 0.
  - Falling edge of 2nd pulse: counter returns to 0. If ar = 1, eoi pulses one cycle.
  - inta edges outside READY are ignored.
- Simultaneous events:
  - An ICW1 in the same cycle as an inta edge wins and the edge is discarded.
  - OCW2 EOI coincident with AEOI yields a single one-cycle eoi pulse.
- Reset mid-sequence returns to the reset values in the next cycle.

Optional Feature:
- Macro CTRLLGC_AEOI_EN.
- Defined: ICW4 D[1] drives ar, and automatic EOI is issued after the 2nd INTA.
- Undefined: ar is constantly 0, ICW4 D[1] is ignored, and eoi comes only from OCW2.

Test Plan:
- Reset, then idle 2 cycles -> int = 0, ino = 0, en = 0, eoi = 0, ar = 0, buff = 0, LTIM = 0, rwadr = 001, Y = 0.
- ICW1 D = 0x1B (a0 = 0), ICW2 0x20, ICW4 0x0B (a0 = 1) -> LTIM = 1, buff = 1, ar = 1 (with CTRLLGC_AEOI_EN), state READY.
- READY, R = 0x04, Mask = 0x00, irr = 1, isr = 0 -> int = 1. Two INTA pulses -> ino one-cycle pulse, Y = 2, int = 0, en = 1 during the 2nd pulse, eoi pulse after it (ar = 1).
- Mask = 0x04 with R = 0x04 -> int stays 0. isr = 1, isprior = 0, Mask = 0 -> int = 0. isprior = 1 -> int = 1.
- OCW3 D = 0x0B (a0 = 0) -> rwadr = 010. rdflag with a0 = 1 -> rwadr = 100 that cycle. OCW2 D = 0x20 -> eoi high exactly 1 cycle.
- Slave: S = 0, SNGL = 0, CLsig = 0 during the 2nd INTA -> en = 0. CLsig = 1 -> en = 1. ICW1 between INTA pulses -> sequence aborted, en stays 0.
